cond_exec_stage: RTL
====================

COND_EXEC_STAGE -- requirements
Module: cond_exec_stage

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  upstream (ALU stage) holds a valid instruction result.
REQ-004 in_ready  output  1  stage can accept; transfer occurs when in_valid & in_ready.
REQ-005 Cond  input  4  ARM condition field of the instruction.
REQ-006 ALUFlags  input  4  ALU flags {N,Z,C,V} = bits [3:0], from ALU of same instruction.
REQ-007 FlagW  input  2  flag write enables: [1] updates N,Z; [0] updates C,V.
REQ-008 Result  input  32  ALU result of same instruction.
REQ-009 RegW, MemW, PCS  input  1 each  unconditioned register-write, memory-write, PC-source requests.
REQ-010 out_valid  output  1  output register holds a valid entry.
REQ-011 out_ready  input  1  downstream accepts; transfer when out_valid & out_ready.
REQ-012 out_Result  output  32  registered Result.
REQ-013 out_RegWrite, out_MemWrite, out_PCSrc  output  1 each  registered requests gated by CondEx.
REQ-014 out_CondEx  output  1  registered condition-pass bit of the entry.
REQ-015 flags_q  output  4  architectural flag register {N,Z,C,V}.
REQ-016 squash_cnt  output  16  count of accepted instructions with CondEx=0 (see Configuration).

Function
REQ-017 CondEx SHALL be evaluated combinationally from Cond and flags_q (value before this instruction's update): 0000 Z; 0001 ~Z; 0010 C; 0011 ~C; 0100 N; 0101 ~N; 0110 V; 0111 ~V; 1000 C&~Z; 1001 ~C|Z; 1010 N==V; 1011 N!=V; 1100 ~Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 0.
REQ-018 in_ready SHALL equal ~out_valid | out_ready (single-entry register slice, no combinational path from in_valid to in_ready).
REQ-019 On accept, the output register SHALL load Result, CondEx, and RegW&CondEx, MemW&CondEx, PCS&CondEx; latency in->out is exactly 1 cycle.
REQ-020 On accept with CondEx=1, flags_q[3:2] SHALL load ALUFlags[3:2] if FlagW[1], and flags_q[1:0] SHALL load ALUFlags[1:0] if FlagW[0]; otherwise flags_q holds.
REQ-021 Flags SHALL NOT change on cycles with no accept, regardless of in_valid, FlagW or ALUFlags.
REQ-022 out_valid SHALL set on accept, clear when out_valid & out_ready & ~accept, and stay set on simultaneous drain and accept (back-to-back, full throughput).
REQ-023 While out_valid & ~out_ready, all out_* signals SHALL hold stable.
REQ-024 Two consecutive accepted instructions: the second SHALL see flags written by the first (no hazard bubble).

Reset
REQ-025 On reset: out_valid=0, flags_q=4'b0000, out_Result=0, out_RegWrite=out_MemWrite=out_PCSrc=out_CondEx=0, squash_cnt=0; reset overrides any simultaneous accept.
REQ-026 in_ready SHALL be 1 in the first cycle after reset deassertion.

Configuration
REQ-027 Macro COND_SQUASH_CNT_EN defined: squash_cnt increments by 1 on each accept with CondEx=0, saturating at 16'hFFFF.
REQ-028 Macro COND_SQUASH_CNT_EN undefined: squash_cnt tied to 16'h0000, no counter register synthesised; all other behaviour identical.

Verification
REQ-029 Reset, then Cond=1110, FlagW=11, ALUFlags=0100, RegW=1, Result=0 -> next cycle out_valid=1, out_RegWrite=1, flags_q=0100.
REQ-030 flags_q=0100, accept Cond=0001 (NE), RegW=1, MemW=1, FlagW=11, ALUFlags=1000 -> out_CondEx=0, out_RegWrite=0, out_MemWrite=0, flags_q stays 0100, squash_cnt +1 (macro on).
REQ-031 flags_q=0000, accept A: Cond=1110, FlagW=01, ALUFlags=0010; next-cycle B: Cond=0010 (CS), PCS=1 -> B out_PCSrc=1, flags_q=0010.
REQ-032 Hold out_ready=0 with in_valid=1 for 3 cycles -> in_ready=0 after first accept, out_Result stable, flags_q unchanged after first accept.
REQ-033 Stream 8 accepts with out_ready=1 continuously -> 8 outputs on 8 consecutive cycles; assert reset mid-stream -> next cycle out_valid=0, flags_q=0000.
REQ-034 Sweep all 16 Cond codes against all 16 flags_q values -> CondEx matches REQ-017 table; Cond=1111 always CondEx=0.

Source files
------------

// File: rtl/cond_exec_stage_if.sv
// cond_exec_stage_if: handshake and data bundle between the ALU stage, the cond-exec stage and its consumer.
// Upstream side: in_valid/in_ready plus Cond, ALUFlags, FlagW, Result, RegW, MemW, PCS.
// Downstream side: out_valid/out_ready plus out_Result, out_RegWrite, out_MemWrite, out_PCSrc, out_CondEx.
// Status: flags_q (architectural {N,Z,C,V}), squash_cnt.
// master drives the stage's inputs (testbench / surrounding pipeline); slave is the stage itself.
interface cond_exec_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Cond;
    logic [3:0]  ALUFlags;
    logic [1:0]  FlagW;
    logic [31:0] Result;
    logic        RegW;
    logic        MemW;
    logic        PCS;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_Result;
    logic        out_RegWrite;
    logic        out_MemWrite;
    logic        out_PCSrc;
    logic        out_CondEx;
    logic [3:0]  flags_q;
    logic [15:0] squash_cnt;
    modport master (
        output in_valid, Cond, ALUFlags, FlagW, Result, RegW, MemW, PCS, out_ready,
        input  in_ready, out_valid, out_Result, out_RegWrite, out_MemWrite, out_PCSrc, out_CondEx,
               flags_q, squash_cnt
    );
    modport slave (
        input  in_valid, Cond, ALUFlags, FlagW, Result, RegW, MemW, PCS, out_ready,
        output in_ready, out_valid, out_Result, out_RegWrite, out_MemWrite, out_PCSrc, out_CondEx,
               flags_q, squash_cnt
    );
endinterface

// File: rtl/cond_exec_stage.sv
// cond_exec_stage: ARM condition-check stage with a single-entry output register slice and flag register.
// Ports: clk, reset (sync, active-high), bus (cond_exec_stage_if.slave) carrying the in/out handshakes,
// instruction fields, gated write requests, flags_q and squash_cnt.
// Optional feature: define COND_SQUASH_CNT_EN to build a saturating counter of squashed instructions;
// otherwise squash_cnt is tied to zero.
module cond_exec_stage (
    input logic              clk,
    input logic              reset,
    cond_exec_stage_if.slave bus
);
    logic        n, z, c, v, cond_ex, accept;
    logic [15:0] pass_tab;
    assign {n, z, c, v} = bus.flags_q;
    // Pass bit per condition code, indexed by Cond (bit 15 = 1111 never, bit 0 = 0000 EQ).
    assign pass_tab = {1'b0, 1'b1, z | (n != v), ~z & (n == v), n != v, n == v, ~c | z, c & ~z,
                       ~v, v, ~n, n, ~c, c, ~z, z};
    assign cond_ex = pass_tab[bus.Cond];
    assign bus.in_ready = ~bus.out_valid | bus.out_ready;
    assign accept = bus.in_valid & bus.in_ready;
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid    <= 1'b0;
            bus.out_Result   <= '0;
            bus.out_RegWrite <= 1'b0;
            bus.out_MemWrite <= 1'b0;
            bus.out_PCSrc    <= 1'b0;
            bus.out_CondEx   <= 1'b0;
            bus.flags_q      <= '0;
        end else begin
            bus.out_valid <= accept | (bus.out_valid & ~bus.out_ready);
            if (accept) begin
                bus.out_Result   <= bus.Result;
                bus.out_RegWrite <= bus.RegW & cond_ex;
                bus.out_MemWrite <= bus.MemW & cond_ex;
                bus.out_PCSrc    <= bus.PCS & cond_ex;
                bus.out_CondEx   <= cond_ex;
                if (cond_ex & bus.FlagW[1]) bus.flags_q[3:2] <= bus.ALUFlags[3:2];
                if (cond_ex & bus.FlagW[0]) bus.flags_q[1:0] <= bus.ALUFlags[1:0];
            end
        end
    end
`ifdef COND_SQUASH_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) bus.squash_cnt <= '0;
        else if (accept & ~cond_ex & ~&bus.squash_cnt) bus.squash_cnt <= bus.squash_cnt + 16'd1;
    end
`else
    assign bus.squash_cnt = '0;
`endif
endmodule
